oc8051_cxrom_fetch: RTL and testbench

//  Instruction-fetch stage between the oc8051 core's instruction bus (wbi_*) and the

---
 rtl/oc8051_cxrom_fetch.sv | 92 +++++++++
 tb/tb_oc8051_cxrom_fetch.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/oc8051_cxrom_fetch.sv
// Instruction-fetch stage between the oc8051 instruction bus and the combinational code ROM.
// A one-entry buffer serves repeated fetches; ROM wait states and hit/miss counters included.
module oc8051_cxrom_fetch #(
    parameter int WAIT_CYCLES = 0,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      wbi_adr_i,
    input  logic             wbi_cyc_i,
    input  logic             wbi_stb_i,
    output logic [31:0]      wbi_dat_o,
    output logic             wbi_ack_o,
    input  logic             flush,
    output logic [15:0]      cxrom_addr,
    input  logic [31:0]      cxrom_data_out,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    typedef enum logic [1:0] {IDLE, FETCH, ACK} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t      state;
    logic        buf_valid;
    logic [15:0] buf_tag;
    logic [31:0] buf_data;
    logic [3:0]  wcnt;

    logic req;
    logic hit;

    assign req = wbi_cyc_i & wbi_stb_i;
    // A flush in the sampling cycle must not let a stale entry satisfy the request.
    assign hit = buf_valid & ~flush & (buf_tag == wbi_adr_i);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            buf_valid  <= 1'b0;
            buf_tag    <= 16'h0;
            buf_data   <= 32'h0;
            wbi_ack_o  <= 1'b0;
            wbi_dat_o  <= 32'h0;
            cxrom_addr <= 16'h0;
            wcnt       <= 4'h0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
        end else begin
            wbi_ack_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        if (hit) begin
                            wbi_dat_o <= buf_data;
                            hit_cnt   <= hit_cnt + CNT_W'(1);
                            wbi_ack_o <= 1'b1;
                            state     <= ACK;
                        end else begin
                            cxrom_addr <= wbi_adr_i;
                            wcnt       <= WAIT_INIT;
                            miss_cnt   <= miss_cnt + CNT_W'(1);
                            state      <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (wcnt != 4'h0) begin
                        wcnt <= wcnt - 4'h1;
                    end else begin
                        buf_data  <= cxrom_data_out;
                        buf_tag   <= cxrom_addr;
                        buf_valid <= 1'b1;
                        wbi_dat_o <= cxrom_data_out;
                        // An aborted cycle still fills the buffer but is never acked.
                        if (wbi_cyc_i) begin
                            wbi_ack_o <= 1'b1;
                            state     <= ACK;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
            if (flush) buf_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_oc8051_cxrom_fetch.sv
// Scoreboard bench: three fetch stages with different wait states / counter widths share
// the bus; a request-level model predicts each ack, a monitor checks what appears.
module tb_oc8051_cxrom_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] adr;
    logic [2:0]  cyc_v;
    logic        stb;
    logic        flush;
    logic [7:0]  rom_gen;

    logic [31:0] dat   [3];
    logic        ack   [3];
    logic [15:0] caddr [3];
    logic [31:0] cxdat [3];
    logic [15:0] hc    [3];
    logic [15:0] mc    [3];
    logic [3:0]  hc2, mc2;

    int total = 0;
    int bad   = 0;
    int cyc_cnt = 0;

    typedef struct {
        int          inst;
        logic [31:0] dat;
        logic [15:0] hc;
        logic [15:0] mc;
        int          cyc;
    } exp_t;

    exp_t q[$];

    // request-level model state per instance
    bit          bv   [3];
    logic [15:0] bt   [3];
    logic [31:0] bd   [3];
    logic [15:0] ca_m [3];
    logic [15:0] hc_m [3];
    logic [15:0] mc_m [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [31:0] rom(input logic [15:0] a, input logic [7:0] g);
        if (a == 16'h0 && g == 8'h0) return 32'h02001234;
        return {a ^ {g, g}, ~a} + 32'h9E37_79B9;
    endfunction

    function automatic int wv(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 3 : 5);
    endfunction

    function automatic logic [15:0] cmask(input int i);
        return (i == 2) ? 16'h000F : 16'hFFFF;
    endfunction

    assign cxdat[0] = rom(caddr[0], rom_gen);
    assign cxdat[1] = rom(caddr[1], rom_gen);
    assign cxdat[2] = rom(caddr[2], rom_gen);
    assign hc[2] = {12'h0, hc2};
    assign mc[2] = {12'h0, mc2};

    oc8051_cxrom_fetch #(.WAIT_CYCLES(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .wbi_adr_i(adr), .wbi_cyc_i(cyc_v[0]), .wbi_stb_i(stb),
        .wbi_dat_o(dat[0]), .wbi_ack_o(ack[0]), .flush(flush), .cxrom_addr(caddr[0]),
        .cxrom_data_out(cxdat[0]), .hit_cnt(hc[0]), .miss_cnt(mc[0]));

    oc8051_cxrom_fetch #(.WAIT_CYCLES(3), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .wbi_adr_i(adr), .wbi_cyc_i(cyc_v[1]), .wbi_stb_i(stb),
        .wbi_dat_o(dat[1]), .wbi_ack_o(ack[1]), .flush(flush), .cxrom_addr(caddr[1]),
        .cxrom_data_out(cxdat[1]), .hit_cnt(hc[1]), .miss_cnt(mc[1]));

    oc8051_cxrom_fetch #(.WAIT_CYCLES(5), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .wbi_adr_i(adr), .wbi_cyc_i(cyc_v[2]), .wbi_stb_i(stb),
        .wbi_dat_o(dat[2]), .wbi_ack_o(ack[2]), .flush(flush), .cxrom_addr(caddr[2]),
        .cxrom_data_out(cxdat[2]), .hit_cnt(hc2), .miss_cnt(mc2));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc_cnt);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < 3; j++) begin
            bv[j] = 0; bt[j] = 16'h0; bd[j] = 32'h0;
            ca_m[j] = 16'h0; hc_m[j] = 16'h0; mc_m[j] = 16'h0;
        end
    endtask

    task automatic check_reset_outputs();
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("rst_dat%0d", j), dat[j], 32'h0);
            chk($sformatf("rst_ack%0d", j), {31'h0, ack[j]}, 32'h0);
            chk($sformatf("rst_caddr%0d", j), {16'h0, caddr[j]}, 32'h0);
            chk($sformatf("rst_hit%0d", j), {16'h0, hc[j]}, 32'h0);
            chk($sformatf("rst_miss%0d", j), {16'h0, mc[j]}, 32'h0);
        end
    endtask

    // Called right after a negedge with the stage idle. Leaves it idle again.
    task automatic req(input int i, input logic [15:0] a, input bit fl_req,
                       input bit fl_cap, input bit abort);
        int          w;
        int          t;
        bit          is_hit;
        logic [31:0] d;
        exp_t        e;
        w = wv(i);
        t = cyc_cnt;
        is_hit = bv[i] && (bt[i] == a) && !fl_req;
        if (fl_req) for (int j = 0; j < 3; j++) bv[j] = 0;
        adr = a; cyc_v[i] = 1'b1; stb = 1'b1; flush = fl_req;
        if (is_hit) begin
            hc_m[i] = (hc_m[i] + 16'h1) & cmask(i);
            e = '{inst: i, dat: bd[i], hc: hc_m[i], mc: mc_m[i], cyc: t + 1};
            q.push_back(e);
            @(negedge clk);
            flush = 1'b0;
            chk("hit_caddr_held", {16'h0, caddr[i]}, {16'h0, ca_m[i]});
            cyc_v[i] = 1'b0; stb = 1'b0;
        end else begin
            mc_m[i] = (mc_m[i] + 16'h1) & cmask(i);
            d = rom(a, rom_gen);
            if (!abort) begin
                e = '{inst: i, dat: d, hc: hc_m[i], mc: mc_m[i], cyc: t + 2 + w};
                q.push_back(e);
            end
            @(negedge clk);
            flush = 1'b0;
            chk("miss_caddr", {16'h0, caddr[i]}, {16'h0, a});
            if (abort) cyc_v[i] = 1'b0;
            repeat (w) @(negedge clk);
            flush = fl_cap;
            @(negedge clk);
            flush = 1'b0;
            chk("caddr_after_fetch", {16'h0, caddr[i]}, {16'h0, a});
            cyc_v[i] = 1'b0; stb = 1'b0;
            ca_m[i] = a;
            if (fl_cap) begin
                for (int j = 0; j < 3; j++) bv[j] = 0;
            end else begin
                bv[i] = 1; bt[i] = a; bd[i] = d;
            end
        end
        @(negedge clk);
    endtask

    // monitor: every ack must match the oldest outstanding expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (ack[i] === 1'b1) begin
                    if (q.size() == 0 || q[0].inst != i) begin
                        total++; bad++;
                        $display("FAIL unexpected_ack inst=%0d: got ack=1 want none (cycle %0d)",
                                 i, cyc_cnt);
                    end else begin
                        e = q.pop_front();
                        chk("ack_cycle", cyc_cnt, e.cyc);
                        chk("ack_dat", dat[i], e.dat);
                        chk("ack_hit_cnt", {16'h0, hc[i]}, {16'h0, e.hc});
                        chk("ack_miss_cnt", {16'h0, mc[i]}, {16'h0, e.mc});
                    end
                end
            end
        end
    end

    initial begin
        logic [15:0] pool [8];
        pool = '{16'h0000, 16'h0001, 16'h0010, 16'h0105, 16'h1234, 16'h8000, 16'hFFFE, 16'hFFFF};
        rst = 1'b0; adr = 16'h0; cyc_v = 3'b0; stb = 1'b0; flush = 1'b0; rom_gen = 8'h0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst = 1'b1;
        @(negedge clk);

        // cold miss then hit on the same address
        req(0, 16'h0000, 0, 0, 0);
        req(0, 16'h0000, 0, 0, 0);
        // three wait states
        req(1, 16'h0105, 0, 0, 0);
        req(1, 16'h0105, 0, 0, 0);
        // standalone flush invalidates
        req(0, 16'h0010, 0, 0, 0);
        flush = 1'b1; for (int j = 0; j < 3; j++) bv[j] = 0;
        @(negedge clk);
        flush = 1'b0;
        req(0, 16'h0010, 0, 0, 0);
        // flush coincident with capture: acked, but buffer stays empty
        req(0, 16'h0030, 0, 1, 0);
        req(0, 16'h0030, 0, 0, 0);
        // aborted fetch still fills the buffer
        req(0, 16'h0020, 0, 0, 1);
        req(0, 16'h0020, 0, 0, 0);
        // flush in the request cycle forces a miss
        req(0, 16'h0020, 1, 0, 0);
        // top address passes straight through
        req(0, 16'hFFFF, 0, 0, 0);
        req(0, 16'hFFFF, 0, 0, 0);

        // reset in the middle of a long fetch
        adr = 16'h0777; cyc_v[2] = 1'b1; stb = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1; cyc_v = 3'b0; stb = 1'b0;
        model_reset();
        check_reset_outputs();
        @(negedge clk);
        req(0, 16'h0000, 0, 0, 0);

        // 4-bit miss counter wraps on the 16th miss
        for (int k = 0; k < 17; k++) req(2, 16'(k * 3 + 1), 0, 0, 0);

        // randomized traffic
        for (int k = 0; k < 150; k++) begin
            int i;
            i = int'($urandom_range(0, 2));
            if ($urandom_range(0, 19) == 0) rom_gen = rom_gen + 8'h1;
            req(i, pool[$urandom_range(0, 7)],
                $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 7) == 0);
        end

        repeat (10) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL missing_acks: got %0d outstanding want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
